// File: rtl/bram_write_ctrl_pkg.sv
// Shared types and constants for the status-BRAM write controller.
`timescale 1ns/1ps
package bram_write_ctrl_pkg;

    // Controller sequence: two write beats, optional two read-back beats, then done.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_LO = 3'd1,
        S_WR_HI = 3'd2,
        S_RD_LO = 3'd3,
        S_RD_HI = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Byte-enable pattern for a full 32-bit beat write.
    localparam logic [3:0] BRAM_WE_ALL = 4'hF;

    // Bytes per BRAM beat; the high beat lives at the low-beat address plus this.
    localparam int BEAT_BYTES = 4;

endpackage

// File: rtl/bram_write_ctrl.sv
// Writes a 64-bit word to a 32-bit native BRAM port as two beats, optionally
// reads both beats back and compares, then pulses WR_DONE (with WR_ERR).
`timescale 1ns/1ps
module bram_write_ctrl
    import bram_write_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit VERIFY = 1'b1,
    parameter int RD_LAT = 2
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              WR_START,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [63:0]       WR_DATA,
    output logic              WR_DONE,
    output logic              WR_ERR,
    output logic              BRAM_EN,
    output logic [3:0]        BRAM_WE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic [31:0]       BRAM_DIN,
    input  logic [31:0]       BRAM_DOUT
);

    // Capture points, counted in clock edges from entry into S_RD_LO.
    localparam logic [2:0]        LO_TAP    = 3'(RD_LAT - 1);
    localparam logic [2:0]        HI_TAP    = 3'(RD_LAT);
    localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(BEAT_BYTES);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   a_reg, a_next;
    logic [63:0]         d_reg, d_next;
    logic                err_reg, err_next;
    logic [2:0]          cnt_reg, cnt_next;

    logic                en_reg, en_next;
    logic [3:0]          we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [31:0]         din_reg, din_next;
    logic                done_reg, done_next;
    logic                werr_reg, werr_next;

    logic                in_read;
    logic                lo_tap;
    logic                hi_tap;
    logic [31:0]         exp_beat;
    logic [BEAT_BYTES-1:0] lane_mis;
    logic                beat_bad;

    assign in_read  = (state_reg == S_RD_LO) || (state_reg == S_RD_HI) || (state_reg == S_WAIT);
    assign lo_tap   = in_read && (cnt_reg == LO_TAP);
    assign hi_tap   = in_read && (cnt_reg == HI_TAP);
    assign exp_beat = hi_tap ? d_reg[63:32] : d_reg[31:0];

    // Per-byte-lane compare of the returning read data against the latched word.
    genvar gi;
    generate
        for (gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
            assign lane_mis[gi] = (BRAM_DOUT[8*gi +: 8] != exp_beat[8*gi +: 8]);
        end
    endgenerate

    assign beat_bad = (lo_tap || hi_tap) && (|lane_mis);

    // Next-state, request latching, read-back compare and next BRAM/handshake outputs.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        d_next     = d_reg;
        err_next   = err_reg;
        cnt_next   = 3'd0;

        case (state_reg)
            S_IDLE: begin
                if (WR_START) begin
                    a_next     = {WR_ADDR[ADDR_W-1:3], 3'b000};
                    d_next     = WR_DATA;
                    err_next   = (WR_ADDR[2:0] != 3'b000);
                    state_next = S_WR_LO;
                end
            end
            S_WR_LO: state_next = S_WR_HI;
            S_WR_HI: state_next = VERIFY ? S_RD_LO : S_DONE;
            S_RD_LO: begin
                cnt_next   = cnt_reg + 3'd1;
                state_next = S_RD_HI;
            end
            S_RD_HI: begin
                // With RD_LAT=1 the high beat is already back here, so WAIT is skipped.
                cnt_next   = cnt_reg + 3'd1;
                state_next = hi_tap ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg + 3'd1;
                if (hi_tap) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if (beat_bad) begin
            err_next = 1'b1;
        end

        // Outputs are registered from the upcoming state so they are glitch-free
        // and line up with the state they belong to.
        en_next   = 1'b0;
        we_next   = 4'h0;
        addr_next = addr_reg;
        din_next  = din_reg;
        done_next = 1'b0;
        werr_next = 1'b0;

        case (state_next)
            S_WR_LO: begin
                en_next   = 1'b1;
                we_next   = BRAM_WE_ALL;
                addr_next = a_next;
                din_next  = d_next[31:0];
            end
            S_WR_HI: begin
                en_next   = 1'b1;
                we_next   = BRAM_WE_ALL;
                addr_next = a_next + BEAT_STEP;
                din_next  = d_next[63:32];
            end
            S_RD_LO: begin
                en_next   = 1'b1;
                addr_next = a_next;
            end
            S_RD_HI: begin
                en_next   = 1'b1;
                addr_next = a_next + BEAT_STEP;
            end
            S_DONE: begin
                done_next = 1'b1;
                werr_next = err_next;
            end
            default: begin
                en_next = 1'b0;
            end
        endcase
    end

    // FSM state register; reset aborts any request in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latched request, latency counter and registered port outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            a_reg    <= '0;
            d_reg    <= '0;
            err_reg  <= 1'b0;
            cnt_reg  <= 3'd0;
            en_reg   <= 1'b0;
            we_reg   <= 4'h0;
            addr_reg <= '0;
            din_reg  <= '0;
            done_reg <= 1'b0;
            werr_reg <= 1'b0;
        end else begin
            a_reg    <= a_next;
            d_reg    <= d_next;
            err_reg  <= err_next;
            cnt_reg  <= cnt_next;
            en_reg   <= en_next;
            we_reg   <= we_next;
            addr_reg <= addr_next;
            din_reg  <= din_next;
            done_reg <= done_next;
            werr_reg <= werr_next;
        end
    end

    assign WR_DONE   = done_reg;
    assign WR_ERR    = werr_reg;
    assign BRAM_EN   = en_reg;
    assign BRAM_WE   = we_reg;
    assign BRAM_ADDR = addr_reg;
    assign BRAM_DIN  = din_reg;

endmodule

// File: tb/tb_bram_write_ctrl.sv
// Bench for bram_write_ctrl: one verifying instance (RD_LAT=2) with a BRAM model,
// one non-verifying instance; randomized requests checked against a reference model.
`timescale 1ns/1ps
module tb_bram_write_ctrl;

    localparam int TB_RD_LAT  = 2;
    localparam int LAT_VERIFY = 4 + TB_RD_LAT;
    localparam int LAT_PLAIN  = 3;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;

    // Verifying instance
    logic        v_start = 1'b0;
    logic [31:0] v_addr = '0;
    logic [63:0] v_data = '0;
    logic        v_done, v_err, v_en;
    logic [3:0]  v_we;
    logic [31:0] v_baddr, v_din, v_dout;

    // Non-verifying instance
    logic        n_start = 1'b0;
    logic [31:0] n_addr = '0;
    logic [63:0] n_data = '0;
    logic        n_done, n_err, n_en;
    logic [3:0]  n_we;
    logic [31:0] n_baddr, n_din;
    logic [31:0] n_dout;

    int n_cmp = 0;
    int n_bad = 0;
    int v_viol = 0;
    int n_viol = 0;

    // BRAM model (single output register => data captured two edges after RD_LO entry)
    logic [31:0] mem [256];
    logic [31:0] rd_q = '0;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;

    // Observed enabled BRAM cycles: {we, addr, din}
    logic [67:0] vlog[$];
    logic [67:0] nlog[$];

    always #5 aclk = ~aclk;

    assign v_dout = rd_q;
    assign n_dout = 32'h0;

    bram_write_ctrl #(.ADDR_W(32), .VERIFY(1'b1), .RD_LAT(TB_RD_LAT)) dut_v (
        .ACLK(aclk), .ARESETN(aresetn),
        .WR_START(v_start), .WR_ADDR(v_addr), .WR_DATA(v_data),
        .WR_DONE(v_done), .WR_ERR(v_err),
        .BRAM_EN(v_en), .BRAM_WE(v_we), .BRAM_ADDR(v_baddr),
        .BRAM_DIN(v_din), .BRAM_DOUT(v_dout)
    );

    bram_write_ctrl #(.ADDR_W(32), .VERIFY(1'b0), .RD_LAT(TB_RD_LAT)) dut_n (
        .ACLK(aclk), .ARESETN(aresetn),
        .WR_START(n_start), .WR_ADDR(n_addr), .WR_DATA(n_data),
        .WR_DONE(n_done), .WR_ERR(n_err),
        .BRAM_EN(n_en), .BRAM_WE(n_we), .BRAM_ADDR(n_baddr),
        .BRAM_DIN(n_din), .BRAM_DOUT(n_dout)
    );

    // BRAM behaviour: full-word writes, registered reads, optional bit0 corruption.
    always @(posedge aclk) begin
        if (v_en && v_we == 4'hF) mem[v_baddr[9:2]] <= v_din;
        if (v_en && v_we == 4'h0)
            rd_q <= mem[v_baddr[9:2]] ^ ((corrupt_en && v_baddr == corrupt_addr) ? 32'h1 : 32'h0);
    end

    // Port monitors, sampled mid-cycle.
    always @(negedge aclk) begin
        if (v_en) vlog.push_back({v_we, v_baddr, v_din});
        if (n_en) nlog.push_back({n_we, n_baddr, n_din});
        if (v_err && !v_done) v_viol++;
        if (n_err && !n_done) n_viol++;
    end

    task automatic wait_done_v(input bit scramble, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge aclk);
            lat++;
            if (v_done) got = 1'b1;
            if (scramble && lat == 1) begin
                v_addr = $urandom;
                v_data = {$urandom, $urandom};
            end
        end
    endtask

    // Issue one request to the verifying instance and check it against the reference.
    task automatic run_v(input logic [31:0] addr, input logic [63:0] data, input bit corrupt,
                         input bit settle, input string nm);
        logic [31:0] al, hi;
        bit          exp_err, got;
        int          lat;
        logic        err_seen;
        al      = {addr[31:3], 3'b000};
        hi      = al + 32'd4;
        exp_err = (addr[2:0] != 3'b000) || corrupt;
        @(negedge aclk);
        corrupt_en   = corrupt;
        corrupt_addr = hi;
        vlog.delete();
        v_start = 1'b1;
        v_addr  = addr;
        v_data  = data;
        wait_done_v(1'b1, lat, got);
        err_seen = v_err;
        v_start  = 1'b0;
        $display("txn %s: addr=%h data=%h corrupt=%0b lat=%0d done=%0b err=%0b",
                 nm, addr, data, corrupt, lat, got, err_seen);
        n_cmp++;
        if (!got || lat != LAT_VERIFY) begin
            n_bad++;
            $display("FAIL %s latency: got %0d (done=%0b) expected %0d", nm, lat, got, LAT_VERIFY);
        end
        n_cmp++;
        if (err_seen !== exp_err) begin
            n_bad++;
            $display("FAIL %s wr_err: got %0b expected %0b", nm, err_seen, exp_err);
        end
        n_cmp++;
        if (vlog.size() != 4) begin
            n_bad++;
            $display("FAIL %s beat count: got %0d expected 4", nm, vlog.size());
        end else begin
            n_cmp++;
            if (vlog[0] !== {4'hF, al, data[31:0]}) begin
                n_bad++;
                $display("FAIL %s write lo: got %h expected %h", nm, vlog[0], {4'hF, al, data[31:0]});
            end
            n_cmp++;
            if (vlog[1] !== {4'hF, hi, data[63:32]}) begin
                n_bad++;
                $display("FAIL %s write hi: got %h expected %h", nm, vlog[1], {4'hF, hi, data[63:32]});
            end
            n_cmp++;
            if (vlog[2][67:32] !== {4'h0, al} || vlog[3][67:32] !== {4'h0, hi}) begin
                n_bad++;
                $display("FAIL %s read-back: got %h/%h expected %h/%h", nm,
                         vlog[2][67:32], vlog[3][67:32], {4'h0, al}, {4'h0, hi});
            end
        end
        if (settle) begin
            repeat (4) @(negedge aclk);
            n_cmp++;
            if (v_done !== 1'b0 || vlog.size() != 4 || v_en !== 1'b0) begin
                n_bad++;
                $display("FAIL %s idle after done: done=%0b en=%0b beats=%0d expected 0/0/4",
                         nm, v_done, v_en, vlog.size());
            end
        end
    endtask

    // Issue one request to the non-verifying instance.
    task automatic run_n(input logic [31:0] addr, input logic [63:0] data, input string nm);
        logic [31:0] al;
        bit          exp_err, got;
        int          lat;
        logic        err_seen;
        al      = {addr[31:3], 3'b000};
        exp_err = (addr[2:0] != 3'b000);
        @(negedge aclk);
        nlog.delete();
        n_start = 1'b1;
        n_addr  = addr;
        n_data  = data;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge aclk);
            lat++;
            if (n_done) got = 1'b1;
        end
        err_seen = n_err;
        n_start  = 1'b0;
        $display("txn %s: addr=%h data=%h lat=%0d done=%0b err=%0b", nm, addr, data, lat, got, err_seen);
        n_cmp++;
        if (!got || lat != LAT_PLAIN) begin
            n_bad++;
            $display("FAIL %s latency: got %0d (done=%0b) expected %0d", nm, lat, got, LAT_PLAIN);
        end
        n_cmp++;
        if (err_seen !== exp_err) begin
            n_bad++;
            $display("FAIL %s wr_err: got %0b expected %0b", nm, err_seen, exp_err);
        end
        n_cmp++;
        if (nlog.size() != 2 || nlog[0] !== {4'hF, al, data[31:0]} ||
            nlog[1] !== {4'hF, al + 32'd4, data[63:32]}) begin
            n_bad++;
            $display("FAIL %s beats: got %0d beats first=%h expected 2 beats first=%h",
                     nm, nlog.size(), (nlog.size() > 0) ? nlog[0] : 68'h0, {4'hF, al, data[31:0]});
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        n_cmp++;
        if ({v_done, v_err, v_en, v_we, v_baddr, v_din} !== '0 ||
            {n_done, n_err, n_en, n_we, n_baddr, n_din} !== '0) begin
            n_bad++;
            $display("FAIL reset outputs: got v=%h n=%h expected 0",
                     {v_done, v_err, v_en, v_we, v_baddr, v_din}, {n_done, n_err, n_en, n_we, n_baddr, n_din});
        end
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_basic_noverify();
        run_n(32'h0, 64'h0, "basic_noverify");
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = $urandom;
            if (i[0]) a[2:0] = 3'b000;
            run_n(a, {$urandom, $urandom}, "rand_noverify");
        end
    endtask

    task automatic test_verify_pass();
        run_v(32'h10, 64'h1122334455667788, 1'b0, 1'b1, "verify_pass");
        n_cmp++;
        if (mem[4] !== 32'h55667788 || mem[5] !== 32'h11223344) begin
            n_bad++;
            $display("FAIL verify_pass mem: got %h/%h expected 55667788/11223344", mem[4], mem[5]);
        end
    endtask

    task automatic test_verify_fail();
        run_v(32'h10, 64'h1122334455667788, 1'b1, 1'b1, "verify_fail");
    endtask

    task automatic test_misaligned();
        run_v(32'h13, {$urandom, $urandom}, 1'b0, 1'b1, "misaligned");
    endtask

    task automatic test_reset_midop();
        int   lat;
        bit   got;
        logic seen_done;
        @(negedge aclk);
        corrupt_en = 1'b0;
        v_start = 1'b1;
        v_addr  = 32'h40;
        v_data  = {$urandom, $urandom};
        repeat (2) @(negedge aclk);
        n_cmp++;
        if (v_en !== 1'b1 || v_we !== 4'hF || v_baddr !== 32'h44) begin
            n_bad++;
            $display("FAIL midop in write-hi: got en=%0b we=%h addr=%h expected 1/f/00000044", v_en, v_we, v_baddr);
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({v_done, v_err, v_en, v_we, v_baddr, v_din} !== '0) begin
            n_bad++;
            $display("FAIL midop reset outputs: got %h expected 0", {v_done, v_err, v_en, v_we, v_baddr, v_din});
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            if (v_done) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_bad++;
            $display("FAIL midop done during reset: got %0b expected 0", seen_done);
        end
        vlog.delete();
        aresetn = 1'b1;
        wait_done_v(1'b0, lat, got);
        v_start = 1'b0;
        $display("txn midop_restart: lat=%0d done=%0b err=%0b beats=%0d", lat, got, v_err, vlog.size());
        n_cmp++;
        if (!got || lat != LAT_VERIFY || vlog.size() != 4) begin
            n_bad++;
            $display("FAIL midop restart: got lat=%0d done=%0b beats=%0d expected %0d/1/4",
                     lat, got, vlog.size(), LAT_VERIFY);
        end
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_handshake_wrap();
        run_v(32'hFFFF_FFF8, {$urandom, $urandom}, 1'b0, 1'b1, "wrap");
        run_n(32'hFFFF_FFF8, {$urandom, $urandom}, "wrap_noverify");
    endtask

    task automatic test_back_to_back();
        run_v(32'h0000_0100, {$urandom, $urandom}, 1'b0, 1'b0, "b2b_first");
        run_v(32'h0000_0208, {$urandom, $urandom}, 1'b0, 1'b1, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            bit          c;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
            c = ($urandom_range(0, 3) == 0);
            run_v(a, {$urandom, $urandom}, c, ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic_noverify();
        test_verify_pass();
        test_verify_fail();
        test_misaligned();
        test_reset_midop();
        test_handshake_wrap();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (v_viol != 0 || n_viol != 0) begin
            n_bad++;
            $display("FAIL err_without_done: got %0d/%0d cycles expected 0", v_viol, n_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
